// File: rtl/bch_pkg.sv
// bch_pkg: shared BCH(31,16) t=3 constants and encoder state type.
// Imported by the encoder and the Berlekamp-Massey decode blocks.
package bch_pkg;

    localparam int BCH_N    = 31;
    localparam int BCH_K    = 16;
    localparam int BCH_P    = BCH_N - BCH_K;
    localparam int BCH_T    = 3;
    localparam int BCH_GF_M = 5;

    localparam logic [15:0] BCH_GEN_POLY  = 16'h8FAF;
    localparam logic [5:0]  BCH_PRIM_POLY = 6'b100101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } bch_enc_state_e;

endpackage

// File: rtl/bch_lfsr_encoder_if.sv
// bch_lfsr_encoder_if: message-in / codeword-out valid/ready bundle.
// master drives messages and accepts codewords; slave is the encoder.
interface bch_lfsr_encoder_if;
    import bch_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BCH_K-1:0]   in_msg;
    logic               out_valid;
    logic               out_ready;
    logic [BCH_N-1:0]   out_code;
    logic               busy;

    modport master (
        output in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_code, busy
    );

    modport slave (
        input  in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_code, busy
    );

endinterface

// File: rtl/bch_parity_lfsr.sv
// bch_parity_lfsr: 15-bit bit-serial divider by g(x), MSB-first input.
// o_parity is the remainder including the bit presented this cycle.
module bch_parity_lfsr
    import bch_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [BCH_P-1:0] o_parity
);

    logic [BCH_P-1:0] r_lfsr;
    logic             w_fb;
    logic [BCH_P-1:0] w_poly;

    assign w_poly = BCH_GEN_POLY[BCH_P-1:0];

    // Feedback of the incoming bit against the top remainder bit
    always_comb begin
        w_fb     = i_bit ^ r_lfsr[BCH_P-1];
        o_parity = {r_lfsr[BCH_P-2:0], 1'b0} ^ (w_fb ? w_poly : '0);
    end

    // Remainder register: cleared per message, advanced per message bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= '0;
        end else if (i_clr) begin
            r_lfsr <= '0;
        end else if (i_en) begin
            r_lfsr <= o_parity;
        end
    end

endmodule

// File: rtl/bch_lfsr_encoder.sv
// bch_lfsr_encoder: systematic BCH(31,16) encoder, one message bit per cycle.
// Option BCH_ENC_ERR_INJECT_EN adds err_mask XORed into the output codeword.
module bch_lfsr_encoder
    import bch_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    bch_lfsr_encoder_if.slave  bus
`ifdef BCH_ENC_ERR_INJECT_EN
    ,
    input  logic [BCH_N-1:0]   err_mask
`endif
);

    bch_enc_state_e     r_state;
    bch_enc_state_e     w_state_nxt;
    logic               r_init;
    logic [3:0]         r_cnt;
    logic [BCH_K-1:0]   r_msg_sh;
    logic [BCH_K-1:0]   r_msg_lat;
    logic [BCH_N-1:0]   r_code;
    logic [BCH_N-1:0]   w_err;
    logic [BCH_P-1:0]   w_parity;
    logic               w_accept;
    logic               w_shift;
    logic               w_done;

`ifdef BCH_ENC_ERR_INJECT_EN
    logic [BCH_N-1:0]   r_err;

    // Error pattern captured together with the message
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= '0;
        end else if (w_accept) begin
            r_err <= err_mask;
        end
    end

    assign w_err = r_err;
`else
    assign w_err = '0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.in_valid && r_init) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == 4'd15) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Message shifter, bit counter and codeword output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_init    <= 1'b0;
            r_cnt     <= 4'd0;
            r_msg_sh  <= '0;
            r_msg_lat <= '0;
            r_code    <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_msg_sh  <= bus.in_msg;
                r_msg_lat <= bus.in_msg;
                r_cnt     <= 4'd0;
            end else if (w_shift) begin
                r_msg_sh  <= {r_msg_sh[BCH_K-2:0], 1'b0};
                r_cnt     <= r_cnt + 4'd1;
            end
            if (w_done) begin
                r_code <= {r_msg_lat, w_parity} ^ w_err;
            end
        end
    end

    bch_parity_lfsr u_lfsr (
        .clk      (clk),
        .rst_n    (reset_n),
        .i_clr    (w_accept),
        .i_en     (w_shift),
        .i_bit    (r_msg_sh[BCH_K-1]),
        .o_parity (w_parity)
    );

    assign bus.in_ready  = r_init && (r_state == ST_IDLE);
    assign bus.out_valid = (r_state == ST_HOLD);
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.out_code  = r_code;

endmodule

// File: tb/tb_bch_lfsr_encoder.sv
// tb_bch_lfsr_encoder: directed vectors against hand-derived codewords.
// Covers reset, latency, backpressure and mid-encode reset abort.
module tb_bch_lfsr_encoder;
    import bch_pkg::*;

    typedef struct {
        logic [15:0] msg;
        logic [30:0] code;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    vec_t tab[7];

    bch_lfsr_encoder_if bus();

`ifdef BCH_ENC_ERR_INJECT_EN
    logic [30:0] err_mask = '0;
`endif

    bch_lfsr_encoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus)
`ifdef BCH_ENC_ERR_INJECT_EN
        ,
        .err_mask (err_mask)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen
    task automatic send(input logic [15:0] m);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_msg   = m;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_msg   = ~m;
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!bus.out_valid && n < 40);
        check("latency", n, 32'd16);
    endtask

    task automatic handoff();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        check("ov_drop", {31'd0, bus.out_valid}, 32'd0);
        check("rdy_back", {31'd0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [30:0] held;

        tab[0] = '{16'h0000, 31'h0000_0000};
        tab[1] = '{16'h0001, 31'h0000_8FAF};
        tab[2] = '{16'h0002, 31'h0001_1F5E};
        tab[3] = '{16'h0003, 31'h0001_90F1};
        tab[4] = '{16'h0004, 31'h0002_3EBC};
        tab[5] = '{16'h8FAF, 31'h47D7_8000};
        tab[6] = '{16'hFFFE, 31'h7FFF_7050};

        bus.in_valid  = 1'b0;
        bus.in_msg    = '0;
        bus.out_ready = 1'b0;

        #12;
        check("rst_rdy", {31'd0, bus.in_ready}, 32'd0);
        check("rst_ov", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_code", {1'b0, bus.out_code}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rdy_pre", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clk);
        check("rdy_post", {31'd0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 7; i++) begin
            send(tab[i].msg);
            check($sformatf("code%0d", i), {1'b0, bus.out_code},
                  {1'b0, tab[i].code});
            check("hold_rdy", {31'd0, bus.in_ready}, 32'd0);
            handoff();
        end

        send(16'hFFFF);
        check("ones", {1'b0, bus.out_code}, 32'h7FFF_FFFF);
        held = 31'h7FFF_FFFF;
        bus.in_valid = 1'b1;
        bus.in_msg   = 16'h1234;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_code", {1'b0, bus.out_code}, {1'b0, held});
            check("bp_rdy", {31'd0, bus.in_ready}, 32'd0);
            check("bp_ov", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("no_overlap", {31'd0, bus.busy}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);

        bus.in_valid = 1'b1;
        bus.in_msg   = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("ab_busy", {31'd0, bus.busy}, 32'd0);
        check("ab_ov", {31'd0, bus.out_valid}, 32'd0);
        check("ab_rdy", {31'd0, bus.in_ready}, 32'd0);
        check("ab_code", {1'b0, bus.out_code}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        send(16'h0001);
        check("post_abort", {1'b0, bus.out_code}, 32'h0000_8FAF);
        handoff();

`ifdef BCH_ENC_ERR_INJECT_EN
        err_mask = 31'h4000_0005;
        bus.in_valid = 1'b1;
        bus.in_msg   = 16'h0001;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        err_mask     = '0;
        repeat (16) @(posedge clk);
        @(negedge clk);
        check("inj_ov", {31'd0, bus.out_valid}, 32'd1);
        check("inj_code", {1'b0, bus.out_code}, 32'h4000_8FAA);
        handoff();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
